// File: rtl/mult_dse_pkg.sv
// Shared types and sizing helpers for multiplier candidate evaluation blocks.
// No logic here; all sizes derive from the operand width.
// Not applicable (package only).
package mult_dse_pkg;

    // Sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest supported per-vector settle wait and the counter width that holds it.
    localparam int SETTLE_MAX = 15;
    localparam int SETTLE_CW  = 4;

    // Product width for a given operand width.
    function automatic int prod_w(input int w);
        return 2 * w;
    endfunction

    // Number of operand pairs in an exhaustive sweep.
    function automatic int vec_count(input int w);
        return 1 << (2 * w);
    endfunction

    // Error counter width: must hold vec_count(w) itself, hence one extra bit.
    function automatic int errcnt_w(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/mult_golden_cmp.sv
// Reference multiply of a*b and compare against a candidate product.
// Purely combinational, zero cycles.
// No handshake; output follows inputs.
module mult_golden_cmp
    import mult_dse_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] p,
    output logic               mismatch
);

    localparam int PW = prod_w(WIDTH);

    logic [PW-1:0] golden;

    // Zero-extend both operands so the product is computed at full width.
    always_comb begin
        golden   = PW'(a) * PW'(b);
        mismatch = (p != golden);
    end

endmodule

// File: rtl/mult_eval_ctrl.sv
// Exhaustive operand sweep of one candidate multiplier, counting mismatches vs a golden product.
// start at edge k -> done from edge k + 2^(2*WIDTH)*(SETTLE+1).
// No backpressure: start is only taken in IDLE/DONE, abort only in SWEEP.
module mult_eval_ctrl
    import mult_dse_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 first_err_valid,
    output logic [WIDTH-1:0]     first_err_a,
    output logic [WIDTH-1:0]     first_err_b,
    output logic [2*WIDTH-1:0]   first_err_p
);

    localparam int PW  = prod_w(WIDTH);
    localparam int ECW = errcnt_w(WIDTH);
    localparam logic [SETTLE_CW-1:0] SETTLE_L = SETTLE_CW'(SETTLE);

    state_t              state, state_nxt;
    logic [PW-1:0]       idx;
    logic [SETTLE_CW-1:0] settle_cnt;
    logic                settle_last;
    logic                idx_last;
    logic                mismatch;
    logic                sweep_clr;
    logic                sweep_abort;
    logic                vec_end;

    // Operands are the two halves of the vector index; B is the fast-moving half.
    assign mul_a = idx[PW-1:WIDTH];
    assign mul_b = idx[WIDTH-1:0];

    assign settle_last = (settle_cnt == SETTLE_L);
    assign idx_last    = (idx == {PW{1'b1}});

    assign busy = (state == SWEEP);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

    mult_golden_cmp #(
        .WIDTH (WIDTH)
    ) u_golden_cmp (
        .a        (mul_a),
        .b        (mul_b),
        .p        (mul_p),
        .mismatch (mismatch)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-edge datapath controls; abort outranks the vector compare.
    always_comb begin
        state_nxt   = state;
        sweep_clr   = 1'b0;
        sweep_abort = 1'b0;
        vec_end     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = SWEEP;
                    sweep_clr = 1'b1;
                end
            end
            SWEEP: begin
                if (abort) begin
                    state_nxt   = IDLE;
                    sweep_abort = 1'b1;
                end else if (settle_last) begin
                    vec_end = 1'b1;
                    if (idx_last) begin
                        state_nxt = DONE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector index, settle counter and result registers; results survive an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx             <= '0;
            settle_cnt      <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_p     <= '0;
        end else if (sweep_clr) begin
            idx             <= '0;
            settle_cnt      <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_p     <= '0;
        end else if (sweep_abort) begin
            idx        <= '0;
            settle_cnt <= '0;
        end else if (vec_end) begin
            if (mismatch) begin
                err_count <= err_count + ECW'(1);
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_a     <= mul_a;
                    first_err_b     <= mul_b;
                    first_err_p     <= mul_p;
                end
            end
            settle_cnt <= '0;
            if (!idx_last) begin
                idx <= idx + PW'(1);
            end
        end else if (state == SWEEP) begin
            settle_cnt <= settle_cnt + SETTLE_CW'(1);
        end
    end

endmodule

// File: tb/tb_mult_eval_ctrl.sv
// Self-checking bench: two instances (SETTLE=0 and SETTLE=2) driving behavioural candidates.
// Expected sweep results come from a software model pushed to a scoreboard queue at start.
// Compared when done rises, or at the abort/reset point for partial sweeps.
module tb_mult_eval_ctrl;

    typedef struct {
        int err;
        int fev;
        int fa;
        int fb;
        int fp;
        int pass;
        int lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // Instance with SETTLE=0
    logic       start0 = 1'b0;
    logic       abort0 = 1'b0;
    logic [1:0] mul_a0, mul_b0;
    logic [3:0] mul_p0;
    logic       busy0, done0, pass0, fev0;
    logic [4:0] err0;
    logic [1:0] fea0, feb0;
    logic [3:0] fep0;
    int         mode0 = 0;

    // Instance with SETTLE=2
    logic       start2 = 1'b0;
    logic       abort2 = 1'b0;
    logic [1:0] mul_a2, mul_b2;
    logic [3:0] mul_p2;
    logic       busy2, done2, pass2, fev2;
    logic [4:0] err2;
    logic [1:0] fea2, feb2;
    logic [3:0] fep2;

    // Candidate behaviours: 0 exact, 1 stuck at zero, 2 bit 0 inverted.
    function automatic logic [3:0] cand(input logic [1:0] a, input logic [1:0] b, input int mode);
        logic [3:0] p;
        p = {2'b00, a} * {2'b00, b};
        case (mode)
            1:       return 4'd0;
            2:       return p ^ 4'd1;
            default: return p;
        endcase
    endfunction

    // Expected result after comparing the first n_vec vectors in sweep order.
    function automatic exp_t model(input int mode, input int n_vec);
        exp_t e;
        e = '{err: 0, fev: 0, fa: 0, fb: 0, fp: 0, pass: 0, lat: 0};
        for (int i = 0; i < n_vec; i++) begin
            logic [1:0] a, b;
            logic [3:0] p;
            a = 2'(i >> 2);
            b = 2'(i);
            p = cand(a, b, mode);
            if (int'(p) != int'(a) * int'(b)) begin
                if (e.fev == 0) begin
                    e.fev = 1;
                    e.fa  = int'(a);
                    e.fb  = int'(b);
                    e.fp  = int'(p);
                end
                e.err++;
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    always_comb mul_p0 = cand(mul_a0, mul_b0, mode0);
    always_comb mul_p2 = cand(mul_a2, mul_b2, 0);

    mult_eval_ctrl #(.WIDTH(2), .SETTLE(0)) dut0 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start0),
        .abort           (abort0),
        .mul_a           (mul_a0),
        .mul_b           (mul_b0),
        .mul_p           (mul_p0),
        .busy            (busy0),
        .done            (done0),
        .pass            (pass0),
        .err_count       (err0),
        .first_err_valid (fev0),
        .first_err_a     (fea0),
        .first_err_b     (feb0),
        .first_err_p     (fep0)
    );

    mult_eval_ctrl #(.WIDTH(2), .SETTLE(2)) dut2 (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start2),
        .abort           (abort2),
        .mul_a           (mul_a2),
        .mul_b           (mul_b2),
        .mul_p           (mul_p2),
        .busy            (busy2),
        .done            (done2),
        .pass            (pass2),
        .err_count       (err2),
        .first_err_valid (fev2),
        .first_err_a     (fea2),
        .first_err_b     (feb2),
        .first_err_p     (fep2)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // All outputs of the SETTLE=0 instance must be zero (reset / cleared state).
    task automatic check_zero0(input string tag);
        check({tag, "_busy"}, int'(busy0), 0);
        check({tag, "_done"}, int'(done0), 0);
        check({tag, "_pass"}, int'(pass0), 0);
        check({tag, "_err"},  int'(err0),  0);
        check({tag, "_fev"},  int'(fev0),  0);
        check({tag, "_fe"},   int'({fea0, feb0, fep0}), 0);
        check({tag, "_ab"},   int'({mul_a0, mul_b0}), 0);
    endtask

    // Pulse start (optionally with abort) on dut0 and check the full sweep result.
    task automatic run_sweep(input string tag, input int mode, input logic with_abort);
        exp_t e;
        int   n, busy_n, ord, both;
        mode0 = mode;
        e     = model(mode, 16);
        e.lat = 16;
        sb.push_back(e);
        @(negedge clk);
        start0 = 1'b1;
        abort0 = with_abort;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        abort0 = 1'b0;
        n = 0; busy_n = 0; ord = 0; both = 0;
        while (!done0 && n < 200) begin
            if (busy0) busy_n++;
            if (busy0 && done0) both++;
            if (int'({mul_a0, mul_b0}) != (n & 15)) ord++;
            @(posedge clk);
            #1;
            n++;
        end
        e = sb.pop_front();
        check({tag, "_lat"},   n,            e.lat);
        check({tag, "_busyn"}, busy_n,       16);
        check({tag, "_order"}, ord,          0);
        check({tag, "_both"},  both,         0);
        check({tag, "_done"},  int'(done0),  1);
        check({tag, "_busy"},  int'(busy0),  0);
        check({tag, "_pass"},  int'(pass0),  e.pass);
        check({tag, "_err"},   int'(err0),   e.err);
        check({tag, "_fev"},   int'(fev0),   e.fev);
        check({tag, "_fea"},   int'(fea0),   e.fa);
        check({tag, "_feb"},   int'(feb0),   e.fb);
        check({tag, "_fep"},   int'(fep0),   e.fp);
    endtask

    // Start dut0 and stop once the vector index reads target.
    task automatic start_and_wait_idx(input string tag, input int target);
        int n;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        n = 0;
        while (int'({mul_a0, mul_b0}) != target && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_reach"}, int'({mul_a0, mul_b0}), target);
    endtask

    initial begin
        exp_t e;
        int   n, run, prev, bad, done_seen;

        // Reset state
        #12;
        check_zero0("rst");
        check("rst_busy2", int'(busy2), 0);
        check("rst_done2", int'(done2), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Exact candidate; abort alongside start from IDLE must be ignored
        run_sweep("exact", 0, 1'b1);
        // Stuck-at-zero candidate, restarted from DONE
        run_sweep("stuck", 1, 1'b0);
        // Bit 0 inverted
        run_sweep("inv", 2, 1'b0);

        // Abort at index 5 (start asserted too: abort wins)
        mode0 = 2;
        e = model(2, 5);
        sb.push_back(e);
        start_and_wait_idx("abort", 5);
        @(negedge clk);
        abort0 = 1'b1;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        abort0 = 1'b0;
        start0 = 1'b0;
        e = sb.pop_front();
        check("abort_busy", int'(busy0), 0);
        check("abort_done", int'(done0), 0);
        check("abort_pass", int'(pass0), 0);
        check("abort_ab",   int'({mul_a0, mul_b0}), 0);
        check("abort_err",  int'(err0), e.err);
        check("abort_fev",  int'(fev0), e.fev);
        check("abort_fe",   int'({fea0, feb0, fep0}), (e.fa << 6) | (e.fb << 4) | e.fp);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done0 || busy0) done_seen++;
        end
        check("abort_idle", done_seen, 0);
        run_sweep("postabort", 0, 1'b0);

        // Asynchronous reset mid-sweep at index 9
        mode0 = 2;
        start_and_wait_idx("arst", 9);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero0("arst");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep("postrst", 2, 1'b0);

        // SETTLE=2, exact candidate, stray start mid-sweep
        e = model(0, 16);
        e.lat = 48;
        sb.push_back(e);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        n = 0; run = 0; bad = 0;
        prev = int'({mul_a2, mul_b2});
        while (!done2 && n < 300) begin
            if (int'({mul_a2, mul_b2}) == prev) begin
                run++;
            end else begin
                if (run != 3) bad++;
                run  = 1;
                prev = int'({mul_a2, mul_b2});
            end
            if (n == 20) start2 = 1'b1;
            @(posedge clk);
            #1;
            start2 = 1'b0;
            n++;
        end
        if (run != 3) bad++;
        e = sb.pop_front();
        check("settle_lat",  n,            e.lat);
        check("settle_hold", bad,          0);
        check("settle_pass", int'(pass2),  e.pass);
        check("settle_err",  int'(err2),   e.err);
        check("settle_fev",  int'(fev2),   e.fev);
        check("settle_busy", int'(busy2),  0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
